// File: rtl/parking_event_monitor_if.sv
// Event record stream between parking_event_monitor (master) and a logger
// or display block (slave), first-word-fall-through valid/ready handshake.
interface parking_event_monitor_if;
   logic        evt_valid;
   logic        evt_ready;
   logic [2:0]  evt_type;
   logic [15:0] evt_plate;
   logic [2:0]  evt_floor;
   logic [7:0]  evt_fee;

   modport master (
      output evt_valid, evt_type, evt_plate, evt_floor, evt_fee,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_type, evt_plate, evt_floor, evt_fee,
      output evt_ready
   );
endinterface

// File: rtl/parking_event_monitor.sv
// Passive observer of the parking_lot_top output bus: turns bus changes into
// typed event records, queues them in a FWFT FIFO and tracks jump/loss errors.
module parking_event_monitor #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [15:0]             moving,
   input  logic [2:0]              current_floor,
   input  logic [7:0]              fee,
   input  logic                    leakage,
   input  logic [2:0]              leakage_floor,
   parking_event_monitor_if.master evt,
   output logic                    err_jump,
   output logic                    overflow,
   output logic [CNT_W-1:0]        dropped_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [2:0] T_BOARD  = 3'd1;
   localparam logic [2:0] T_ALIGHT = 3'd2;
   localparam logic [2:0] T_MOVE   = 3'd3;
   localparam logic [2:0] T_JUMP   = 3'd4;
   localparam logic [2:0] T_LEAK   = 3'd5;

   typedef struct packed {
      logic [2:0]  typ;
      logic [15:0] plate;
      logic [2:0]  floor;
      logic [7:0]  fee;
   } rec_t;

   function automatic logic [3:0] abs4(input logic signed [3:0] v);
      return v[3] ? 4'(-v) : 4'(v);
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0]       inc);
      logic [CNT_W:0] sum;
      sum = (CNT_W+1)'(a) + (CNT_W+1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic              armed;
   logic [15:0]       prev_moving;
   logic [2:0]        prev_floor;
   logic              prev_leak;

   rec_t              mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  occ;

   logic signed [3:0] dflr_p0;
   logic [3:0]        adst_p0;
   logic              jump_p0, alight_p0, board_p0, move_p0, leak_p0;
   logic [2:0]        n_evt_p0;
   logic              vld_p0;
   rec_t              rec_p0;

   logic              full, pop, accept, drop_win;
   logic [2:0]        lost;
   rec_t              head;

   // p0: compare sampled bus against previous sample, pick highest-priority event
   always_comb begin
      dflr_p0   = $signed({1'b0, current_floor}) - $signed({1'b0, prev_floor});
      adst_p0   = abs4(dflr_p0);
      jump_p0   = armed && (adst_p0 > 4'd1);
      move_p0   = armed && (adst_p0 == 4'd1);
      alight_p0 = armed && (moving != prev_moving) && (moving == 16'd0);
      board_p0  = armed && (moving != prev_moving) && (moving != 16'd0);
      leak_p0   = armed && leakage && !prev_leak;
      n_evt_p0  = {2'b0, jump_p0} + {2'b0, alight_p0} + {2'b0, board_p0}
                + {2'b0, move_p0} + {2'b0, leak_p0};
      vld_p0    = (n_evt_p0 != 3'd0);

      rec_p0 = '0;
      if (jump_p0) begin
         rec_p0.typ   = T_JUMP;
         rec_p0.plate = moving;
         rec_p0.floor = current_floor;
      end else if (alight_p0) begin
         rec_p0.typ   = T_ALIGHT;
         rec_p0.plate = prev_moving;
         rec_p0.floor = current_floor;
         rec_p0.fee   = fee;
      end else if (board_p0) begin
         rec_p0.typ   = T_BOARD;
         rec_p0.plate = moving;
         rec_p0.floor = current_floor;
      end else if (move_p0) begin
         rec_p0.typ   = T_MOVE;
         rec_p0.plate = moving;
         rec_p0.floor = current_floor;
      end else if (leak_p0) begin
         rec_p0.typ   = T_LEAK;
         rec_p0.floor = leakage_floor;
      end
   end

   // A full FIFO still takes the new record when the head leaves on the same edge
   assign full     = (occ == OCC_W'(DEPTH));
   assign pop      = evt.evt_valid && evt.evt_ready;
   assign accept   = vld_p0 && (!full || pop);
   assign drop_win = vld_p0 && !accept;
   assign lost     = vld_p0 ? (n_evt_p0 - 3'd1 + {2'b0, drop_win}) : 3'd0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         armed       <= 1'b0;
         prev_moving <= '0;
         prev_floor  <= '0;
         prev_leak   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         err_jump    <= 1'b0;
         overflow    <= 1'b0;
         dropped_cnt <= '0;
      end else begin
         armed       <= 1'b1;
         prev_moving <= moving;
         prev_floor  <= current_floor;
         prev_leak   <= leakage;
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         occ <= occ + OCC_W'(accept) - OCC_W'(pop);
         if (jump_p0)     err_jump    <= 1'b1;
         if (drop_win)    overflow    <= 1'b1;
         if (lost != 3'd0) dropped_cnt <= sat_add(dropped_cnt, lost);
      end
   end

   always_ff @(posedge clock) begin
      if (accept) mem[wr_ptr] <= rec_p0;
   end

   // FIFO head drives the stream directly; fields read as zero while empty
   assign head          = mem[rd_ptr];
   assign evt.evt_valid = (occ != '0);

   always_comb begin
      evt.evt_type  = '0;
      evt.evt_plate = '0;
      evt.evt_floor = '0;
      evt.evt_fee   = '0;
      if (evt.evt_valid) begin
         evt.evt_type  = head.typ;
         evt.evt_plate = head.plate;
         evt.evt_floor = head.floor;
         evt.evt_fee   = head.fee;
      end
   end

endmodule

// File: tb/tb_parking_event_monitor.sv
// Bench for parking_event_monitor: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the event rules.
module tb_parking_event_monitor;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [15:0]       moving = '0;
   logic [2:0]        current_floor = '0;
   logic [7:0]        fee = '0;
   logic              leakage = 1'b0;
   logic [2:0]        leakage_floor = '0;
   logic              ready = 1'b0;
   logic              err_jump;
   logic              overflow;
   logic [CNT_W-1:0]  dropped_cnt;

   parking_event_monitor_if ev_if ();
   assign ev_if.evt_ready = ready;

   parking_event_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .moving        (moving),
      .current_floor (current_floor),
      .fee           (fee),
      .leakage       (leakage),
      .leakage_floor (leakage_floor),
      .evt           (ev_if),
      .err_jump      (err_jump),
      .overflow      (overflow),
      .dropped_cnt   (dropped_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      int typ;
      int plate;
      int floor;
      int fee;
   } rec_t;

   rec_t q[$];
   bit   m_armed, m_err, m_ovf, m_prev_leak;
   int   m_drop, m_prev_moving, m_prev_floor;
   int   checks, errors;

   function automatic rec_t mk(input int t, input int p, input int f, input int fe);
      rec_t r;
      r.typ = t; r.plate = p; r.floor = f; r.fee = fe;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_armed = 0; m_err = 0; m_ovf = 0; m_prev_leak = 0;
      m_drop = 0; m_prev_moving = 0; m_prev_floor = 0;
   endtask

   // One clock edge of the event rules, from the inputs held at that edge.
   task automatic model_edge();
      bit   pop, acc;
      int   d, ad, lost;
      rec_t ev[$];
      pop = (q.size() > 0) && (ready == 1'b1);
      acc = 0;
      if (m_armed) begin
         d  = int'(current_floor) - m_prev_floor;
         ad = (d < 0) ? -d : d;
         if (ad > 1) begin
            ev.push_back(mk(4, int'(moving), int'(current_floor), 0));
            m_err = 1;
         end
         if (int'(moving) != m_prev_moving) begin
            if (moving == 16'd0) ev.push_back(mk(2, m_prev_moving, int'(current_floor), int'(fee)));
            else                 ev.push_back(mk(1, int'(moving), int'(current_floor), 0));
         end
         if (ad == 1) ev.push_back(mk(3, int'(moving), int'(current_floor), 0));
         if (leakage && !m_prev_leak) ev.push_back(mk(5, 0, int'(leakage_floor), 0));
         if (ev.size() > 0) begin
            lost = ev.size() - 1;
            acc  = (q.size() < DEPTH) || pop;
            if (!acc) begin
               m_ovf = 1;
               lost++;
            end
            m_drop = (m_drop + lost > CNT_MAX) ? CNT_MAX : m_drop + lost;
         end
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ev[0]);
      m_armed       = 1;
      m_prev_moving = int'(moving);
      m_prev_floor  = int'(current_floor);
      m_prev_leak   = leakage;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".valid"}, 32'(ev_if.evt_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk({ctx, ".type"},  32'(ev_if.evt_type),  q[0].typ);
         chk({ctx, ".plate"}, 32'(ev_if.evt_plate), q[0].plate);
         chk({ctx, ".floor"}, 32'(ev_if.evt_floor), q[0].floor);
         chk({ctx, ".fee"},   32'(ev_if.evt_fee),   q[0].fee);
      end
      chk({ctx, ".err_jump"}, 32'(err_jump),    32'(m_err));
      chk({ctx, ".overflow"}, 32'(overflow),    32'(m_ovf));
      chk({ctx, ".dropped"},  32'(dropped_cnt), m_drop);
   endtask

   task automatic check_reset(input string ctx);
      chk({ctx, ".valid"},    32'(ev_if.evt_valid), 0);
      chk({ctx, ".type"},     32'(ev_if.evt_type),  0);
      chk({ctx, ".plate"},    32'(ev_if.evt_plate), 0);
      chk({ctx, ".floor"},    32'(ev_if.evt_floor), 0);
      chk({ctx, ".fee"},      32'(ev_if.evt_fee),   0);
      chk({ctx, ".err_jump"}, 32'(err_jump),        0);
      chk({ctx, ".overflow"}, 32'(overflow),        0);
      chk({ctx, ".dropped"},  32'(dropped_cnt),     0);
   endtask

   task automatic tick(input string ctx);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all(ctx);
   endtask

   // Asynchronous assertion mid-cycle, release on a falling edge, then arming edge.
   task automatic do_reset(input string ctx);
      #2 reset = 1'b0;
      #1 model_reset();
      check_reset(ctx);
      @(negedge clock);
      reset = 1'b1;
      tick({ctx, ".arm"});
   endtask

   logic [15:0] plates [4];

   initial begin
      checks = 0;
      errors = 0;
      plates[0] = 16'h0000; plates[1] = 16'h8754; plates[2] = 16'h9423; plates[3] = 16'h1234;
      ready = 1'b1;
      model_reset();
      #1 check_reset("por");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tick("arm");

      moving = 16'h8754;
      tick("board");
      chk("board.type_k",  32'(ev_if.evt_type),  1);
      chk("board.plate_k", 32'(ev_if.evt_plate), 32'h8754);
      chk("board.fee_k",   32'(ev_if.evt_fee),   0);
      tick("board_gone");
      chk("board.one_cycle", 32'(ev_if.evt_valid), 0);

      current_floor = 3'd1;
      tick("move1");
      chk("move1.floor_k", 32'(ev_if.evt_floor), 1);
      current_floor = 3'd2;
      tick("move2");
      chk("move2.type_k", 32'(ev_if.evt_type), 3);
      moving = 16'h0000; fee = 8'd50;
      tick("alight");
      chk("alight.type_k",  32'(ev_if.evt_type),  2);
      chk("alight.plate_k", 32'(ev_if.evt_plate), 32'h8754);
      chk("alight.fee_k",   32'(ev_if.evt_fee),   50);
      fee = 8'd0;

      current_floor = 3'd1;
      tick("move_down");
      current_floor = 3'd4;
      tick("jump");
      chk("jump.type_k",  32'(ev_if.evt_type),  4);
      chk("jump.floor_k", 32'(ev_if.evt_floor), 4);
      chk("jump.err_k",   32'(err_jump),        1);
      current_floor = 3'd3;
      tick("clean1");
      current_floor = 3'd2;
      tick("clean2");

      moving = 16'h9423; current_floor = 3'd3;
      tick("board_move");
      chk("board_move.type_k",  32'(ev_if.evt_type),  1);
      chk("board_move.plate_k", 32'(ev_if.evt_plate), 32'h9423);
      chk("board_move.drop_k",  32'(dropped_cnt),     1);
      chk("board_move.ovf_k",   32'(overflow),        0);
      chk("sticky_jump_k",      32'(err_jump),        1);

      do_reset("rst1");

      ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         current_floor = (i % 2 == 0) ? 3'd4 : 3'd3;
         tick("fill");
      end
      chk("fill.ovf_k",  32'(overflow),    1);
      chk("fill.drop_k", 32'(dropped_cnt), 1);
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain.order_k", 32'(ev_if.evt_floor), (i % 2 == 0) ? 4 : 3);
         tick("drain");
      end
      chk("drain.empty_k", 32'(ev_if.evt_valid), 0);

      ready = 1'b0;
      leakage = 1'b1; leakage_floor = 3'd5;
      repeat (3) tick("leak_hold");
      leakage = 1'b0;
      tick("leak_low");
      chk("leak.type_k",  32'(ev_if.evt_type),  5);
      chk("leak.floor_k", 32'(ev_if.evt_floor), 5);
      chk("leak.plate_k", 32'(ev_if.evt_plate), 0);
      ready = 1'b1;
      tick("leak_pop");
      chk("leak.single_k", 32'(ev_if.evt_valid), 0);
      ready = 1'b0;
      current_floor = 3'd3;
      tick("queued");
      do_reset("rst_queued");

      for (int i = 0; i < 300; i++) begin
         current_floor = (i % 2 == 0) ? 3'd4 : 3'd3;
         tick("sat");
      end
      chk("sat.drop_k", 32'(dropped_cnt), CNT_MAX);

      do_reset("rst_rand");
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) >= 7) moving = plates[$urandom_range(0, 3)];
         case ($urandom_range(0, 9))
            7:       current_floor = (current_floor == 3'd7) ? 3'd6 : current_floor + 3'd1;
            8:       current_floor = (current_floor == 3'd0) ? 3'd1 : current_floor - 3'd1;
            9:       current_floor = 3'($urandom_range(0, 7));
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) leakage = ~leakage;
         leakage_floor = 3'($urandom_range(0, 7));
         fee           = 8'($urandom_range(0, 255));
         ready         = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         if (i == 500) do_reset("rst_mid_rand");
         else          tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/parking_event_monitor.md
Name: parking_event_monitor

Overview:
- Passive observer on the `parking_lot_top` output bus, instantiated beside the controller.
- Samples `moving`, `current_floor`, `fee`, `leakage` and `leakage_floor` every clock and turns their changes into typed event records: board, alight, floor move, illegal jump, leakage.
- Records are buffered in a FIFO and drained over a valid/ready stream by a logger or display block.
- Produces sticky error flags for illegal multi-floor jumps and for event loss.

Parameters:
- DEPTH, 8: event FIFO entries; power of two, 2..16.
- CNT_W, 8: width of the saturating dropped-event counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 clears all state immediately; release is sampled on `clock`.
- moving  in  16  plate currently in the elevator (4 BCD digits); 0 means empty.
- current_floor  in  3  elevator floor, 0..7.
- fee  in  8  parking fee in cents, valid in the cycle the car alights.
- leakage  in  1  leakage alarm level.
- leakage_floor  in  3  floor of the leakage.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_type  out  3  1=BOARD, 2=ALIGHT, 3=MOVE, 4=JUMP, 5=LEAK.
- evt_plate  out  16  plate associated with the event.
- evt_floor  out  3  floor associated with the event.
- evt_fee  out  8  fee for ALIGHT, 0 for all other types.
- err_jump  out  1  sticky: a JUMP event was detected.
- overflow  out  1  sticky: an event was lost because the FIFO was full.
- dropped_cnt  out  CNT_W  saturating count of lost events (FIFO full or priority loss).

Behaviour:
- Reset (reset=0): FIFO empty, `evt_valid`=0, all `evt_*` fields=0, `err_jump`=0, `overflow`=0, `dropped_cnt`=0. Internal prev_moving=0, prev_floor=0, prev_leak=0, armed=0.
- Arming: the first rising edge after reset release only loads the prev registers and sets armed=1. No events are generated on that edge. Events are generated from the next edge onward.
- Detection: each edge with armed=1 compares the sampled inputs against the prev registers.
  - d = current_floor − prev_floor, computed as 4-bit signed.
  - JUMP: |d| > 1. Record plate=moving, floor=current_floor.
  - ALIGHT: moving != prev_moving and moving == 0. Record plate=prev_moving, floor=current_floor, fee=fee.
  - BOARD: moving != prev_moving and moving != 0. Record plate=moving, floor=current_floor. A direct nonzero→nonzero swap yields BOARD only.
  - MOVE: |d| == 1. Record plate=moving, floor=current_floor.
  - LEAK: leakage=1 and prev_leak=0 (rising edge only). Record plate=0, floor=leakage_floor.
- One push per cycle. Priority: JUMP > ALIGHT > BOARD > MOVE > LEAK.
  - Each lower-priority event detected in the same cycle increments `dropped_cnt` by 1.
  - The increment does not set `overflow`.
- The prev registers update on every edge, including edges where an event is dropped.
- FIFO behaviour:
  - First-word-fall-through; `evt_valid` = not empty, and the `evt_*` fields show the head entry.
  - Pop when evt_valid & evt_ready.
  - Latency: a record pushed at edge N is visible on the outputs after edge N when the FIFO was empty.
  - Full, no pop: the new event is discarded, `overflow` is set, `dropped_cnt` increments.
  - Full with a simultaneous pop: the push is accepted and occupancy stays DEPTH.
  - Empty with a push and `evt_ready`=1: the pop is ignored because `evt_valid` was 0; the entry remains.
- Pointers wrap modulo DEPTH; an occupancy counter distinguishes full from empty.
- `dropped_cnt` saturates at 2^CNT_W−1 and never wraps.
- `err_jump` and `overflow` clear only on reset.
- Every field is held stable while evt_valid=1 and evt_ready=0.
- Asserting reset mid-stream discards all FIFO contents and clears the flags asynchronously.
- After release, the arming rule applies again.

Test Plan:
- Reset release, then `moving` 0→16'h8754 at floor 0, `evt_ready`=1 → one record: BOARD, plate 8754, floor 0, fee 0, `evt_valid` high for exactly 1 cycle.
- Floor 0→1→2 with `moving`=16'h8754 → two MOVE records, floors 1 then 2. Next `moving`→0 with fee=8'd50 at floor 2 → ALIGHT, plate 8754, floor 2, fee 50.
- `current_floor` 1→4 in one cycle → JUMP, floor 4; `err_jump`=1 and remains 1 through later clean traffic until reset.
- Same edge: `moving` 0→16'h9423 and floor 2→3 → only BOARD (plate 9423, floor 3) enqueued; `dropped_cnt`=1; `overflow`=0.
- `evt_ready`=0, generate 9 MOVE events with DEPTH=8 → 8 entries held, `overflow`=1, `dropped_cnt`=1. Raise `evt_ready` → entries drain in order; `evt_valid` falls after the 8th pop.
- `leakage` held 1 for 3 cycles, `leakage_floor`=5 → exactly one LEAK record, floor 5. Pull reset low with entries queued → `evt_valid`=0 immediately and all flags cleared.
